// File: rtl/store_unit_if.sv
// Store request and memory write port bundle for store_unit.
// The store unit takes the slave view; control plus memory take the master view.
interface store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  st_req;
  logic [2:0]            st_funct3;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [31:0]           st_data;
  logic                  st_ready;
  logic                  st_done;
  logic                  st_fault;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_byte_enable;
  logic                  mem_write;
  logic                  mem_resp;

  modport master (
    output st_req, st_funct3, st_addr, st_data, mem_resp,
    input  st_ready, st_done, st_fault, mem_address, mem_wdata, mem_byte_enable, mem_write
  );

  modport slave (
    input  st_req, st_funct3, st_addr, st_data, mem_resp,
    output st_ready, st_done, st_fault, mem_address, mem_wdata, mem_byte_enable, mem_write
  );
endinterface

// File: rtl/store_unit.sv
// RV32I store unit: turns SB/SH/SW requests into word-aligned, lane-enabled memory writes.
// Define MISALIGNED_STORE_SPLIT_EN to split misaligned stores instead of faulting them.
module store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
`ifdef MISALIGNED_STORE_SPLIT_EN
    WR_HI = 2'd2,
`endif
    RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic                  st_done_q, st_done_d;
  logic                  st_fault_q, st_fault_d;

  logic [3:0]            size_mask_s;
  logic [31:0]           data_masked_s;
  logic [1:0]            off_s;
  logic                  illegal_s;
  logic                  misaligned_s;
  logic [3:0]            lo_be_s;
  logic [31:0]           lo_wdata_s;
  logic [ADDR_WIDTH-1:0] lo_addr_s;

`ifdef MISALIGNED_STORE_SPLIT_EN
  logic [7:0]            lane_s;
  logic [63:0]           lane_data_s;
  logic                  crossing_s;
  logic [ADDR_WIDTH-1:0] hi_addr_s;
  logic                  crossing_q, crossing_d;
  logic [ADDR_WIDTH-1:0] hi_address_q, hi_address_d;
  logic [31:0]           hi_wdata_q, hi_wdata_d;
  logic [3:0]            hi_be_q, hi_be_d;

  assign hi_addr_s = lo_addr_s + {{(ADDR_WIDTH-3){1'b0}}, 3'b100};
`endif

  assign off_s     = bus.st_addr[1:0];
  assign lo_addr_s = {bus.st_addr[ADDR_WIDTH-1:2], 2'b00};

  // Request decode: size mask, masked data, lane placement and alignment fault.
  always_comb begin
    size_mask_s   = 4'b0000;
    data_masked_s = 32'd0;
    illegal_s     = 1'b0;
    misaligned_s  = 1'b0;
    case (bus.st_funct3)
      3'b000: begin
        size_mask_s   = 4'b0001;
        data_masked_s = {24'd0, bus.st_data[7:0]};
      end
      3'b001: begin
        size_mask_s   = 4'b0011;
        data_masked_s = {16'd0, bus.st_data[15:0]};
      end
      3'b010: begin
        size_mask_s   = 4'b1111;
        data_masked_s = bus.st_data;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
`ifdef MISALIGNED_STORE_SPLIT_EN
    lane_s      = {4'b0000, size_mask_s} << off_s;
    lane_data_s = {32'd0, data_masked_s} << {off_s, 3'b000};
    lo_be_s     = lane_s[3:0];
    lo_wdata_s  = lane_data_s[31:0];
    crossing_s  = (lane_s[7:4] != 4'b0000);
`else
    lo_be_s    = size_mask_s << off_s;
    lo_wdata_s = data_masked_s << {off_s, 3'b000};
    if (bus.st_funct3 == 3'b001) begin
      misaligned_s = off_s[0];
    end else if (bus.st_funct3 == 3'b010) begin
      misaligned_s = (off_s != 2'b00);
    end else begin
      misaligned_s = 1'b0;
    end
`endif
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    st_done_d     = 1'b0;
    st_fault_d    = 1'b0;
`ifdef MISALIGNED_STORE_SPLIT_EN
    crossing_d    = crossing_q;
    hi_address_d  = hi_address_q;
    hi_wdata_d    = hi_wdata_q;
    hi_be_d       = hi_be_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.st_req) begin
          if (illegal_s || misaligned_s) begin
            state_d    = RESP;
            st_done_d  = 1'b1;
            st_fault_d = 1'b1;
          end else begin
            state_d       = WR_LO;
            mem_write_d   = 1'b1;
            mem_address_d = lo_addr_s;
            mem_wdata_d   = lo_wdata_s;
            mem_be_d      = lo_be_s;
`ifdef MISALIGNED_STORE_SPLIT_EN
            crossing_d    = crossing_s;
            hi_address_d  = hi_addr_s;
            hi_wdata_d    = lane_data_s[63:32];
            hi_be_d       = lane_s[7:4];
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_LO: begin
        if (bus.mem_resp) begin
`ifdef MISALIGNED_STORE_SPLIT_EN
          // The high half follows on the same edge so mem_write never drops between halves.
          if (crossing_q) begin
            state_d       = WR_HI;
            mem_address_d = hi_address_q;
            mem_wdata_d   = hi_wdata_q;
            mem_be_d      = hi_be_q;
          end else begin
            state_d     = RESP;
            mem_write_d = 1'b0;
            st_done_d   = 1'b1;
          end
`else
          state_d     = RESP;
          mem_write_d = 1'b0;
          st_done_d   = 1'b1;
`endif
        end else begin
          state_d = WR_LO;
        end
      end
`ifdef MISALIGNED_STORE_SPLIT_EN
      WR_HI: begin
        if (bus.mem_resp) begin
          state_d     = RESP;
          mem_write_d = 1'b0;
          st_done_d   = 1'b1;
        end else begin
          state_d = WR_HI;
        end
      end
`endif
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= 32'd0;
      mem_be_q      <= 4'b0000;
      st_done_q     <= 1'b0;
      st_fault_q    <= 1'b0;
`ifdef MISALIGNED_STORE_SPLIT_EN
      crossing_q    <= 1'b0;
      hi_address_q  <= '0;
      hi_wdata_q    <= 32'd0;
      hi_be_q       <= 4'b0000;
`endif
    end else begin
      state_q       <= state_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      st_done_q     <= st_done_d;
      st_fault_q    <= st_fault_d;
`ifdef MISALIGNED_STORE_SPLIT_EN
      crossing_q    <= crossing_d;
      hi_address_q  <= hi_address_d;
      hi_wdata_q    <= hi_wdata_d;
      hi_be_q       <= hi_be_d;
`endif
    end
  end

  assign bus.st_ready        = (state_q == IDLE);
  assign bus.st_done         = st_done_q;
  assign bus.st_fault        = st_fault_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_byte_enable = mem_be_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit; expected values are hand-computed.
module tb_store_unit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  store_unit_if #(.ADDR_WIDTH(32)) bus ();

  store_unit #(.ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    bus.st_req    = 1'b1;
    bus.st_funct3 = f3;
    bus.st_addr   = addr;
    bus.st_data   = data;
    tick();
    bus.st_req    = 1'b0;
  endtask

  task automatic check_mem(input string tag, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata);
    check_eq({tag, "_write"}, bus.mem_write, 1'b1);
    check_eq({tag, "_addr"}, bus.mem_address, addr);
    check_eq({tag, "_be"}, bus.mem_byte_enable, be);
    check_eq({tag, "_wdata"}, bus.mem_wdata, wdata);
  endtask

  task automatic check_done(input string tag, input logic fault);
    check_eq({tag, "_done"}, bus.st_done, 1'b1);
    check_eq({tag, "_fault"}, bus.st_fault, fault);
    check_eq({tag, "_nowrite"}, bus.mem_write, 1'b0);
    tick();
    check_eq({tag, "_done_clr"}, bus.st_done, 1'b0);
    check_eq({tag, "_ready"}, bus.st_ready, 1'b1);
  endtask

  task automatic respond;
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.st_req    = 1'b0;
    bus.st_funct3 = 3'b000;
    bus.st_addr   = 32'd0;
    bus.st_data   = 32'd0;
    bus.mem_resp  = 1'b0;
    #12;
    check_eq("rst_ready", bus.st_ready, 1'b1);
    check_eq("rst_write", bus.mem_write, 1'b0);
    check_eq("rst_addr", bus.mem_address, 32'd0);
    check_eq("rst_wdata", bus.mem_wdata, 32'd0);
    check_eq("rst_be", bus.mem_byte_enable, 4'b0000);
    check_eq("rst_done", bus.st_done, 1'b0);
    check_eq("rst_fault", bus.st_fault, 1'b0);
    rst = 1'b1;
    tick();

    // SB into the top lane, memory answers on the second write cycle
    issue(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    check_mem("sb", 32'h0000_1000, 4'b1000, 32'hDD00_0000);
    check_eq("sb_busy", bus.st_ready, 1'b0);
    tick();
    check_mem("sb_hold", 32'h0000_1000, 4'b1000, 32'hDD00_0000);
    respond();
    check_done("sb", 1'b0);

    // SW with a slow memory; a request while busy must be dropped
    issue(3'b010, 32'h0000_2000, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      check_mem("sw_hold", 32'h0000_2000, 4'b1111, 32'h1234_5678);
      if (i == 2) begin
        bus.st_req    = 1'b1;
        bus.st_funct3 = 3'b000;
        bus.st_addr   = 32'h0000_9999;
        bus.st_data   = 32'hFFFF_FFFF;
      end
      tick();
    end
    check_mem("sw_last", 32'h0000_2000, 4'b1111, 32'h1234_5678);
    bus.st_req = 1'b0;
    respond();
    check_done("sw", 1'b0);
    tick();
    check_eq("sw_no_queue", bus.mem_write, 1'b0);
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    check_eq("stray_resp_done", bus.st_done, 1'b0);
    check_eq("stray_resp_write", bus.mem_write, 1'b0);

    // Aligned SH in the upper half
    issue(3'b001, 32'h0000_3002, 32'h0000_BEEF);
    check_mem("sh_hi", 32'h0000_3000, 4'b1100, 32'hBEEF_0000);
    respond();
    check_done("sh_hi", 1'b0);

`ifdef MISALIGNED_STORE_SPLIT_EN
    issue(3'b001, 32'h0000_3003, 32'h0000_BEEF);
    check_mem("sh_split_lo", 32'h0000_3000, 4'b1000, 32'hEF00_0000);
    respond();
    check_mem("sh_split_hi", 32'h0000_3004, 4'b0001, 32'h0000_00BE);
    respond();
    check_done("sh_split", 1'b0);

    issue(3'b010, 32'hFFFF_FFFE, 32'h1122_3344);
    check_mem("sw_wrap_lo", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
    respond();
    check_mem("sw_wrap_hi", 32'h0000_0000, 4'b0011, 32'h0000_1122);
    tick();
    check_mem("sw_wrap_hold", 32'h0000_0000, 4'b0011, 32'h0000_1122);
    respond();
    check_done("sw_wrap", 1'b0);
`else
    issue(3'b001, 32'h0000_3003, 32'h0000_BEEF);
    check_done("sh_mis", 1'b1);
    issue(3'b010, 32'hFFFF_FFFE, 32'h1122_3344);
    check_done("sw_mis", 1'b1);
`endif

    issue(3'b111, 32'h0000_3000, 32'h0000_BEEF);
    check_done("f3_illegal", 1'b1);

    // Asynchronous reset in the middle of a write
    issue(3'b010, 32'h0000_4000, 32'hCAFE_F00D);
    check_eq("pre_rst_write", bus.mem_write, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst_write", bus.mem_write, 1'b0);
    check_eq("async_rst_ready", bus.st_ready, 1'b1);
    check_eq("async_rst_done", bus.st_done, 1'b0);
    check_eq("async_rst_addr", bus.mem_address, 32'd0);
    #3;
    rst = 1'b1;
    tick();
    check_eq("post_rst_done", bus.st_done, 1'b0);
    check_eq("post_rst_write", bus.mem_write, 1'b0);
    issue(3'b000, 32'h0000_4001, 32'h0000_0055);
    check_mem("post_rst_sb", 32'h0000_4000, 4'b0010, 32'h0000_5500);
    respond();
    check_done("post_rst_sb", 1'b0);

    // Back-to-back: new request in the cycle right after st_done
    issue(3'b000, 32'h0000_5000, 32'h0000_007F);
    check_mem("b2b_first", 32'h0000_5000, 4'b0001, 32'h0000_007F);
    respond();
    check_eq("b2b_done", bus.st_done, 1'b1);
    tick();
    check_eq("b2b_ready", bus.st_ready, 1'b1);
    issue(3'b001, 32'h0000_5002, 32'h1234_A5A5);
    check_mem("b2b_second", 32'h0000_5000, 4'b1100, 32'hA5A5_0000);
    respond();
    check_done("b2b_second", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
